// File: rtl/rns_mod_fold_seq.sv
// Iterative N mod MOD: folds PERIOD-bit groups (2^PERIOD == 1 mod MOD), re-folds, then conditionally subtracts.
// Optional macro RNS_FOLD_OPCNT_EN adds an op_count port counting completed output handshakes.
module rns_mod_fold_seq #(
  parameter  int N_SIZE = 16,
  parameter  int MOD    = 21,
  parameter  int PERIOD = 6,
  localparam int NUM_G  = (N_SIZE + PERIOD - 1) / PERIOD,
  localparam int ACC_W  = PERIOD + $clog2(NUM_G),
  localparam int RES_W  = $clog2(MOD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_SIZE-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_res,
  output logic [2:0]        dbg_state
`ifdef RNS_FOLD_OPCNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds until out_ready.
  localparam int GRP_W = (NUM_G > 1) ? $clog2(NUM_G) : 1;
  localparam int PAD_W = NUM_G * PERIOD;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FOLD   = 3'd1,
    S_REFOLD = 3'd2,
    S_CORR   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [PAD_W-1:0]   opnd_q, opnd_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [PERIOD-1:0]  grp_bits;

  // Operand is stored zero-padded so the top group reads zeros above N_SIZE.
  always_comb begin
    grp_bits = '0;
    for (int g = 0; g < NUM_G; g++) begin
      if (grp_q == GRP_W'(g)) grp_bits = opnd_q[g*PERIOD +: PERIOD];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    grp_d   = grp_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opnd_d  = PAD_W'(in_data);
          acc_d   = '0;
          grp_d   = '0;
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        acc_d = acc_q + ACC_W'(grp_bits);
        grp_d = grp_q + 1'b1;
        if (grp_q == GRP_W'(NUM_G - 1)) state_d = S_REFOLD;
      end
      S_REFOLD: begin
        if (acc_q >= ACC_W'(1 << PERIOD)) begin
          acc_d = ACC_W'(acc_q[PERIOD-1:0]) + (acc_q >> PERIOD);
        end else begin
          state_d = S_CORR;
        end
      end
      S_CORR: begin
        if (acc_q >= ACC_W'(MOD)) begin
          acc_d = acc_q - ACC_W'(MOD);
        end else begin
          res_d   = acc_q[RES_W-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      grp_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      grp_q   <= grp_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_res   = res_q;
  assign dbg_state = state_q;

`ifdef RNS_FOLD_OPCNT_EN
  logic [15:0] op_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else if (out_valid && out_ready) op_count_q <= op_count_q + 16'd1;
  end
  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_rns_mod_fold_seq.sv
// Directed and randomized bench for rns_mod_fold_seq: residue, latency, stall hold and async reset abort.
module tb_rns_mod_fold_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_res;
  logic [2:0]  dbg_state;
`ifdef RNS_FOLD_OPCNT_EN
  logic [15:0] op_count;
`endif

  int total = 0;
  int bad   = 0;
  int hs_count = 0;
  logic [4:0] exp_q[$];

  rns_mod_fold_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .dbg_state (dbg_state)
`ifdef RNS_FOLD_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Sends n, checks result/latency (lat<0 skips latency), stalls, then completes the handshake.
  task automatic run_op(input logic [15:0] n, input int exp_lat, input int stall, input string tag);
    int lat;
    int waited;
    logic [4:0] exp_res;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check({tag, "_rdy"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = n;
    exp_q.push_back(5'(n % 16'd21));
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = $urandom_range(0, 65535);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    exp_res = exp_q.pop_front();
    check({tag, "_res"}, int'(out_res), int'(exp_res));
    if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
    else if (lat >= 20) check({tag, "_timeout"}, lat, 9);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_res !== exp_res)
        check({tag, "_hold"}, {out_valid, in_ready, out_res}, {1'b1, 1'b0, exp_res});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    hs_count++;
    out_ready = 1'b0;
    check({tag, "_ret"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_res", int'(out_res), 0);
    check("rst_state", int'(dbg_state), 0);
    do_reset();

    run_op(16'd0,     5, 0, "n0");
    run_op(16'd65535, 6, 0, "n65535");
    run_op(16'd1000,  7, 0, "n1000");
    run_op(16'd63,    8, 0, "n63");
    run_op(16'd4095,  9, 0, "n4095");
    run_op(16'd21,    6, 0, "n21");
    run_op(16'd20,    5, 0, "n20");
    run_op(16'd64,    5, 0, "n64");
    run_op(16'd1000,  7, 5, "stall");

    // Abort in FOLD after grp has advanced to 1; out_res still holds 13 from the last op.
    in_valid = 1'b1;
    in_data  = 16'd12345;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_res", int'(out_res), 0);
    check("abort_state", int'(dbg_state), 0);
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef RNS_FOLD_OPCNT_EN
    check("abort_opcnt", int'(op_count), 0);
`endif
    hs_count = 0;
    run_op(16'd1000, 7, 0, "post_rst");

    for (int k = 0; k < 2000; k++) begin
      run_op(16'($urandom_range(0, 65535)), -1, $urandom_range(0, 3), "rand");
    end

`ifdef RNS_FOLD_OPCNT_EN
    check("opcnt", int'(op_count), hs_count);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
